uart_baudgen_frac: RTL

Parametrised fractional baud-rate generator for the APB UART. It is the successor of the integer-only baud tick generator.
- Produces a one-cycle oversample strobe (OS_TICK) whose average period is DIV_INT + DIV_FRAC/2^FRAC_W enabled clock cycles.
- Produces a bit strobe (BIT_TICK) every OSR oversample strobes.
- Carries a shadowed divider, so software can reprogram the rate without a glitched period.
- Sits between the UART register file (divisor latches) and the TX/RX serialisers.

---
 rtl/uart_baudgen_frac.sv | 108 ++++++++++
 1 files changed

// File: rtl/uart_baudgen_frac.sv
// Fractional baud-rate generator: oversample strobe, bit strobe and oversample phase.
// Define UART_BAUDGEN_FRAC_EN to include the fractional phase accumulator.
module uart_baudgen_frac #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned OSR    = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CE,
  input  logic                    CLEAR,
  input  logic [DIV_W-1:0]        DIV_INT,
  input  logic [FRAC_W-1:0]       DIV_FRAC,
  input  logic                    DIV_LOAD,
  output logic                    OS_TICK,
  output logic                    BIT_TICK,
  output logic [$clog2(OSR)-1:0]  OS_PHASE
);

  localparam int unsigned PH_W = $clog2(OSR);

  logic [DIV_W-1:0]  act_int;
  logic [DIV_W-1:0]  d_act;
  logic [DIV_W-1:0]  d_new;
  logic [DIV_W-1:0]  d_clear;
  logic [DIV_W-1:0]  reload;
  logic [DIV_W-1:0]  cnt;
  logic [PH_W-1:0]   phase_inc;
  logic              carry;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      act_int <= '0;
    end else if (DIV_LOAD) begin
      act_int <= DIV_INT;
    end
  end

`ifdef UART_BAUDGEN_FRAC_EN
  logic [FRAC_W-1:0] act_frac;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   acc_sum;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      act_frac <= '0;
    end else if (DIV_LOAD) begin
      act_frac <= DIV_FRAC;
    end
  end

  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, act_frac};
    carry   = acc_sum[FRAC_W];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc <= '0;
    end else if (CLEAR) begin
      acc <= '0;
    end else if (CE && (cnt == '0)) begin
      acc <= acc_sum[FRAC_W-1:0];
    end
  end
`else
  logic frac_unused;
  assign frac_unused = ^DIV_FRAC;
  assign carry       = 1'b0;
`endif

  // A load coinciding with CLEAR takes effect for the restarted period;
  // otherwise the running period keeps the old divider until its reload.
  always_comb begin
    d_act     = (act_int == '0) ? DIV_W'(1) : act_int;
    d_new     = (DIV_INT == '0) ? DIV_W'(1) : DIV_INT;
    d_clear   = DIV_LOAD ? d_new : d_act;
    reload    = d_act - DIV_W'(1) + DIV_W'(carry);
    phase_inc = (OS_PHASE == PH_W'(OSR - 1)) ? '0 : OS_PHASE + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt      <= '0;
      OS_PHASE <= '0;
      OS_TICK  <= 1'b0;
      BIT_TICK <= 1'b0;
    end else if (CLEAR) begin
      cnt      <= d_clear - DIV_W'(1);
      OS_PHASE <= '0;
      OS_TICK  <= 1'b0;
      BIT_TICK <= 1'b0;
    end else if (CE && (cnt == '0)) begin
      cnt      <= reload;
      OS_PHASE <= phase_inc;
      OS_TICK  <= 1'b1;
      BIT_TICK <= (OS_PHASE == PH_W'(OSR - 1));
    end else if (CE) begin
      cnt      <= cnt - DIV_W'(1);
      OS_TICK  <= 1'b0;
      BIT_TICK <= 1'b0;
    end else begin
      OS_TICK  <= 1'b0;
      BIT_TICK <= 1'b0;
    end
  end

endmodule
